// File: rtl/regfile_writer.sv
// regfile_writer: 32x32 register file write port with a 32-cycle sequential clear
module regfile_writer #(
  parameter logic [31:0] RESET_VAL = 32'h00000000,
  parameter bit          R0_ZERO   = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        WE,
  input  logic [4:0]  WA,
  input  logic [31:0] WD,
  input  logic        CLR,
  output logic        Ready,
  output logic [7:0]  WrCount,
  output logic [31:0] Q0,
  output logic [31:0] Q1,
  output logic [31:0] Q2,
  output logic [31:0] Q3,
  output logic [31:0] Q4,
  output logic [31:0] Q5,
  output logic [31:0] Q6,
  output logic [31:0] Q7,
  output logic [31:0] Q8,
  output logic [31:0] Q9,
  output logic [31:0] Q10,
  output logic [31:0] Q11,
  output logic [31:0] Q12,
  output logic [31:0] Q13,
  output logic [31:0] Q14,
  output logic [31:0] Q15,
  output logic [31:0] Q16,
  output logic [31:0] Q17,
  output logic [31:0] Q18,
  output logic [31:0] Q19,
  output logic [31:0] Q20,
  output logic [31:0] Q21,
  output logic [31:0] Q22,
  output logic [31:0] Q23,
  output logic [31:0] Q24,
  output logic [31:0] Q25,
  output logic [31:0] Q26,
  output logic [31:0] Q27,
  output logic [31:0] Q28,
  output logic [31:0] Q29,
  output logic [31:0] Q30,
  output logic [31:0] Q31
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t      state, state_nx;
  logic [4:0]  idx, idx_nx;
  logic [7:0]  wr_count;
  logic [31:0] q [32];
  logic [31:0] wr_sel, clr_sel;
  logic        accept;
  always_comb begin
    accept   = WE && state == IDLE;
    wr_sel   = accept ? (32'd1 << WA) & ~{31'd0, R0_ZERO} : 32'd0;
    clr_sel  = state == CLEAR ? 32'd1 << idx : 32'd0;
    state_nx = state == IDLE ? (CLR ? CLEAR : IDLE) : (idx == 5'd31 ? IDLE : CLEAR);
    idx_nx   = state == CLEAR ? idx + 5'd1 : 5'd0;
  end
  // writes only happen in IDLE and clears only in CLEAR, so the selects never overlap
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      idx      <= 5'd0;
      wr_count <= 8'd0;
      for (int i = 0; i < 32; i++) q[i] <= RESET_VAL;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      wr_count <= wr_count + {7'd0, accept};
      for (int i = 0; i < 32; i++)
        if (clr_sel[i]) q[i] <= RESET_VAL;
        else if (wr_sel[i]) q[i] <= WD;
    end
  end
  assign Ready   = state == IDLE;
  assign WrCount = wr_count;
  assign Q0  = q[0];
  assign Q1  = q[1];
  assign Q2  = q[2];
  assign Q3  = q[3];
  assign Q4  = q[4];
  assign Q5  = q[5];
  assign Q6  = q[6];
  assign Q7  = q[7];
  assign Q8  = q[8];
  assign Q9  = q[9];
  assign Q10 = q[10];
  assign Q11 = q[11];
  assign Q12 = q[12];
  assign Q13 = q[13];
  assign Q14 = q[14];
  assign Q15 = q[15];
  assign Q16 = q[16];
  assign Q17 = q[17];
  assign Q18 = q[18];
  assign Q19 = q[19];
  assign Q20 = q[20];
  assign Q21 = q[21];
  assign Q22 = q[22];
  assign Q23 = q[23];
  assign Q24 = q[24];
  assign Q25 = q[25];
  assign Q26 = q[26];
  assign Q27 = q[27];
  assign Q28 = q[28];
  assign Q29 = q[29];
  assign Q30 = q[30];
  assign Q31 = q[31];
endmodule
